sudoku_grid_loader: RTL and testbench



---
 rtl/sudoku_pkg.sv | 49 ++++
 rtl/sudoku_unit_dup.sv | 36 +++
 rtl/sudoku_grid_loader.sv | 163 ++++++++++++++++
 tb/tb_sudoku_grid_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and index helpers for the sudoku grid loader.
// Latency: none (declarations and pure functions only).
// Backpressure: n/a.
//
// Grid layout: cell k (k = 9*row + col) lives at grid[4k+4:4k+1], so the
// grid bus is indexed [GRID_W:1] and row r spans [36r+36:36r+1].
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int DW     = 4;
  localparam int GRID_W = CELLS * DW;
  localparam int UNITS  = 27;
  localparam int USIZE  = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    FIRE,
    HOLD,
    ERROR
  } state_t;

  // Bit index of the least-significant bit of cell k on the [GRID_W:1] bus.
  function automatic int cell_lsb(input int k);
    return DW * k + 1;
  endfunction

  // Cell index of the i-th member of unit u.
  // u = 0..8 rows, 9..17 columns, 18..26 boxes (box b at rows 3*(b/3).., cols 3*(b%3)..).
  function automatic int unit_cell(input int u, input int i);
    int b;
    int r;
    int c;
    if (u < 9) begin
      r = u;
      c = i;
    end else if (u < 18) begin
      r = i;
      c = u - 9;
    end else begin
      b = u - 18;
      r = 3 * (b / 3) + i / 3;
      c = 3 * (b % 3) + i % 3;
    end
    return 9 * r + c;
  endfunction

endpackage

// File: rtl/sudoku_unit_dup.sv
// Duplicate detector for one sudoku unit (row, column or box) of nine cells.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   i_unit  in  36  nine packed 4-bit digits, member i at [4i+3:4i]
//   o_dup   out 1   high when two members hold the same nonzero digit
module sudoku_unit_dup
  import sudoku_pkg::*;
(
  input  logic [USIZE*DW-1:0] i_unit,
  output logic                o_dup
);

  logic [USIZE-1:0] w_seen;
  logic [DW-1:0]    w_d;

  // One-hot mask of digits already met while walking the nine members.
  // Zeros are blanks; anything above 9 is never stored by the loader but is
  // ignored here too so the mask index cannot run off the end.
  always_comb begin
    w_seen = '0;
    w_d    = '0;
    o_dup  = 1'b0;
    for (int i = 0; i < USIZE; i++) begin
      w_d = i_unit[DW*i +: DW];
      if ((w_d != '0) && (w_d <= 4'd9)) begin
        if (w_seen[w_d - 4'd1]) begin
          o_dup = 1'b1;
        end
        w_seen[w_d - 4'd1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sudoku_grid_loader.sv
// Packs a row-major stream of 81 digits into a 324-bit grid, validates it, pulses start.
// Latency: last beat in cycle N -> start in N+28 (N+1 when the duplicate scan is disabled).
// Backpressure: s_ready high only in IDLE/LOAD; deasserted while checking, firing and holding.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready/s_digit/s_sof input beat handshake, digit, start-of-frame marker
//   clear                         release held grid or abort the current frame
//   grid                          packed grid, cell k at grid[4k+4:4k+1]
//   start                         one-cycle pulse when a validated grid is presented
//   grid_ok                       high while the accepted grid is held
//   err_range/err_dup/err_frame   sticky error flags, cleared by clear or rst
module sudoku_grid_loader
  import sudoku_pkg::*;
#(
  parameter bit CHECK_DUP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_digit,
  input  logic              s_sof,
  input  logic              clear,
  output logic [GRID_W:1]   grid,
  output logic              start,
  output logic              grid_ok,
  output logic              err_range,
  output logic              err_dup,
  output logic              err_frame
);

  state_t              r_state;
  logic [GRID_W:1]     r_grid;
  logic [6:0]          r_idx;
  logic [4:0]          r_unit;
  logic                r_err_range;
  logic                r_err_dup;
  logic                r_err_frame;

  logic                w_accept;
  logic                w_bad;
  logic [DW-1:0]       w_digit;
  logic [USIZE*DW-1:0] w_unit;
  logic                w_dup;

  // clear has priority over a beat even in IDLE, where s_ready is still high.
  assign w_accept = s_valid && s_ready && !clear;
  assign w_bad    = (s_digit > 4'd9);
  assign w_digit  = w_bad ? '0 : s_digit;

  // Gather the nine cells of the unit under test; one unit per CHECK cycle.
  always_comb begin
    w_unit = '0;
    for (int i = 0; i < USIZE; i++) begin
      w_unit[DW*i +: DW] = r_grid[cell_lsb(unit_cell(int'(r_unit), i)) +: DW];
    end
  end

  sudoku_unit_dup u_dup (
    .i_unit (w_unit),
    .o_dup  (w_dup)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grid      <= '0;
      r_idx       <= '0;
      r_unit      <= '0;
      r_err_range <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_frame <= 1'b0;
    end else if (clear) begin
      // Abort/release from any state. In FIRE the start pulse is already
      // decoded from the current state, so it still appears this cycle.
      r_state     <= IDLE;
      r_grid      <= '0;
      r_idx       <= '0;
      r_unit      <= '0;
      r_err_range <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (s_sof) begin
              r_grid[cell_lsb(0) +: DW] <= w_digit;
              r_idx                     <= 7'd1;
              r_state                   <= LOAD;
              if (w_bad) begin
                r_err_range <= 1'b1;
              end
            end else begin
              // Stray beat outside a frame: dropped, flagged.
              r_err_frame <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (w_accept) begin
            if (w_bad) begin
              r_err_range <= 1'b1;
            end
            if (s_sof) begin
              // Upstream restarted mid-frame: follow it rather than stall.
              r_grid[cell_lsb(0) +: DW] <= w_digit;
              r_idx                     <= 7'd1;
              r_err_frame               <= 1'b1;
            end else begin
              r_grid[cell_lsb(int'(r_idx)) +: DW] <= w_digit;
              if (r_idx == 7'(CELLS - 1)) begin
                r_unit  <= '0;
                r_state <= CHECK_DUP ? CHECK : FIRE;
              end else begin
                r_idx <= r_idx + 7'd1;
              end
            end
          end
        end

        CHECK: begin
          if (w_dup) begin
            r_err_dup <= 1'b1;
          end
          if (r_unit == 5'(UNITS - 1)) begin
            // Fold in this cycle's result; r_err_dup is not yet updated.
            r_state <= (r_err_range || r_err_dup || w_dup) ? ERROR : FIRE;
          end else begin
            r_unit <= r_unit + 5'd1;
          end
        end

        FIRE: begin
          r_state <= HOLD;
        end

        HOLD: begin
          r_state <= HOLD;
        end

        ERROR: begin
          r_state <= ERROR;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_ready   = (r_state == IDLE) || (r_state == LOAD);
  assign start     = (r_state == FIRE);
  assign grid_ok   = (r_state == HOLD);
  assign grid      = r_grid;
  assign err_range = r_err_range;
  assign err_dup   = r_err_dup;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_sudoku_grid_loader.sv
// Self-checking bench for sudoku_grid_loader: frames are streamed, expected
// outcomes are queued when a frame is driven and compared when it completes.
module tb_sudoku_grid_loader;

  typedef logic [323:0] val_t;

  typedef struct {
    val_t grid;
    bit   fire;
    bit   er;
    bit   ed;
    bit   ef;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [3:0]   s_digit;
  logic         s_sof;
  logic         clear;
  logic [324:1] grid;
  logic         start;
  logic         grid_ok;
  logic         err_range;
  logic         err_dup;
  logic         err_frame;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   frame[81];
  exp_t sb[$];
  val_t last_grid;

  sudoku_grid_loader #(.CHECK_DUP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_digit   (s_digit),
    .s_sof     (s_sof),
    .clear     (clear),
    .grid      (grid),
    .start     (start),
    .grid_ok   (grid_ok),
    .err_range (err_range),
    .err_dup   (err_dup),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start === 1'b1) n_start++;
  end

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic fill_solved();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        frame[9*r+c] = ((r * 3 + r / 3 + c) % 9) + 1;
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 81; k++) frame[k] = 0;
  endtask

  // Reference outcome: out-of-range digits zeroed, duplicates by pairwise
  // comparison of cells sharing a row, column or box.
  task automatic push_expected(input bit ef);
    exp_t e;
    int   d[81];
    e.grid = '0;
    e.er   = 1'b0;
    e.ed   = 1'b0;
    e.ef   = ef;
    for (int k = 0; k < 81; k++) begin
      d[k] = frame[k];
      if (d[k] > 9) begin
        e.er = 1'b1;
        d[k] = 0;
      end
      e.grid[4*k +: 4] = 4'(d[k]);
    end
    for (int a = 0; a < 81; a++)
      for (int b = a + 1; b < 81; b++)
        if (d[a] != 0 && d[a] == d[b]) begin
          if ((a / 9 == b / 9) || (a % 9 == b % 9) ||
              ((a / 27 == b / 27) && ((a % 9) / 3 == (b % 9) / 3)))
            e.ed = 1'b1;
        end
    e.fire = !(e.er || e.ed);
    sb.push_back(e);
  endtask

  task automatic beat(input int k, input bit sof);
    s_valid = 1'b1;
    s_digit = 4'(frame[k]);
    s_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic stream_frame(input bit restart30);
    if (restart30)
      for (int k = 0; k < 30; k++) beat(k, k == 0);
    for (int k = 0; k < 81; k++) beat(k, k == 0);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit restart30, input bit ef);
    push_expected(ef);
    stream_frame(restart30);
  endtask

  // Wait (bounded) for the start pulse after the last beat, then compare
  // against the oldest queued expectation.
  task automatic collect();
    exp_t e;
    int   lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("sb_size", val_t'(sb.size()), val_t'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("start_cycle", val_t'(lat), e.fire ? val_t'(28) : '0);
    chk("grid", val_t'(grid), e.grid);
    chk("err_range", val_t'(err_range), val_t'(e.er));
    chk("err_dup", val_t'(err_dup), val_t'(e.ed));
    chk("err_frame", val_t'(err_frame), val_t'(e.ef));
    last_grid = e.grid;
    @(negedge clk);
    chk("start_width", val_t'(start), '0);
    chk("grid_ok", val_t'(grid_ok), val_t'(e.fire));
    chk("s_ready_busy", val_t'(s_ready), '0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grid"}, val_t'(grid), '0);
    chk({tag, "_start"}, val_t'(start), '0);
    chk({tag, "_grid_ok"}, val_t'(grid_ok), '0);
    chk({tag, "_s_ready"}, val_t'(s_ready), val_t'(1));
    chk({tag, "_err_range"}, val_t'(err_range), '0);
    chk({tag, "_err_dup"}, val_t'(err_dup), '0);
    chk({tag, "_err_frame"}, val_t'(err_frame), '0);
  endtask

  initial begin
    int pa[4];
    int pb[4];
    int ns;
    pa = '{2, 0, 4, 60};
    pb = '{7, 10, 76, 80};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_digit = '0;
    clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Solved grid with a blank first cell.
    fill_solved();
    frame[0] = 0;
    send_frame(1'b0, 1'b0);
    collect();

    // Beats offered while holding are refused and the grid stays put.
    s_valid = 1'b1;
    s_sof   = 1'b1;
    s_digit = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_s_ready", val_t'(s_ready), '0);
      chk("hold_grid", val_t'(grid), last_grid);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    clear_pulse();
    @(negedge clk);
    check_idle("release");

    // Out-of-range digit in the centre cell.
    fill_solved();
    frame[40] = 11;
    send_frame(1'b0, 1'b0);
    collect();
    chk("cell40", val_t'(grid[164:161]), '0);
    clear_pulse();

    // Duplicates in a row, a box, a column and the last box.
    for (int t = 0; t < 4; t++) begin
      fill_zero();
      frame[pa[t]] = 5;
      frame[pb[t]] = 5;
      send_frame(1'b0, 1'b0);
      collect();
      clear_pulse();
    end

    // clear wins over a beat offered in IDLE.
    @(negedge clk);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_sof   = 1'b1;
    s_digit = 4'd7;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    @(negedge clk);
    chk("clear_wins_grid", val_t'(grid), '0);

    // Frame restarted with s_sof at beat 30.
    fill_solved();
    send_frame(1'b1, 1'b1);
    collect();
    clear_pulse();

    // Beat without s_sof in IDLE is dropped and flagged.
    s_valid = 1'b1;
    s_sof   = 1'b0;
    s_digit = 4'd4;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("stray_err_frame", val_t'(err_frame), val_t'(1));
    chk("stray_grid", val_t'(grid), '0);
    clear_pulse();

    // Reset during CHECK cycle 10 (frame carries a range error beforehand).
    fill_solved();
    frame[5] = 12;
    stream_frame(1'b0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    ns  = n_start;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
    repeat (40) @(negedge clk);
    chk("mid_rst_no_start", val_t'(n_start), val_t'(ns));

    fill_solved();
    send_frame(1'b0, 1'b0);
    collect();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
